hazard_ctrl: RTL and testbench

- Pipeline hazard and stall scheduler for the 5-stage core with branches resolved in ID.
- Each cycle it decides whether the PC advances, whether the IF/ID register holds or flushes, and whether a bubble goes into ID/EX.
- Handles load-use hazards, branch-on-fresh-operand hazards (up to 2 bubbles), taken-branch flush, instruction-fetch not-ready, and data-memory stall freeze.
- Sits beside the IF/ID and ID/EX registers and drives their hold/flush inputs.

---
 rtl/hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble scheduler for a 5-stage pipeline that resolves branches in ID.
// Optional macro HAZARD_PERF_CNT_EN adds the saturating stall and flush performance counters.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_i,
    input  logic             id_branch_taken_i,
    input  logic [4:0]       ex_wreg_i,
    input  logic             ex_regwrite_i,
    input  logic             ex_memread_i,
    input  logic             imem_ready_i,
    input  logic             dmem_stall_i,
    output logic             pc_write_o,
    output logic             ifid_hz_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL1   = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e     state_q, state_d, run_next_s;
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
    logic       match_s, lu_s, brh_s;
    logic       run_pc_s, run_hz_s, run_flush_s, run_bubble_s, run_freeze_s;
    logic       pc_write_s, ifid_hz_s, ifid_flush_s, idex_bubble_s, freeze_s;

    assign match_s = (ex_wreg_i != 5'd0) &&
                     ((ex_wreg_i == id_rs_i) || (id_uses_rt_i && (ex_wreg_i == id_rt_i)));
    assign lu_s    = ex_memread_i && match_s;
    assign brh_s   = id_branch_i && ex_regwrite_i && match_s;

    // RUN-state priority decision; also reused by MEM_WAIT on the release cycle
    always_comb begin
        run_pc_s     = 1'b1;
        run_hz_s     = 1'b0;
        run_flush_s  = 1'b0;
        run_bubble_s = 1'b0;
        run_freeze_s = 1'b0;
        run_next_s   = RUN;
        if (dmem_stall_i) begin
            run_freeze_s = 1'b1;
            run_pc_s     = 1'b0;
            run_hz_s     = 1'b1;
            run_next_s   = MEM_WAIT;
        end else if (lu_s || brh_s) begin
            run_pc_s     = 1'b0;
            run_hz_s     = 1'b1;
            run_bubble_s = 1'b1;
            run_next_s   = (lu_s && id_branch_i) ? STALL1 : RUN;
        end else if (id_branch_taken_i) begin
            run_flush_s  = 1'b1;
            run_pc_s     = 1'b1;
        end else if (!imem_ready_i) begin
            run_pc_s     = 1'b0;
            run_flush_s  = 1'b1;
        end else begin
            run_pc_s     = 1'b1;
        end
    end

    // Output selection and next state per current state
    always_comb begin
        pc_write_s    = 1'b1;
        ifid_hz_s     = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        freeze_s      = 1'b0;
        state_d       = state_q;
        if (rst_i) begin
            pc_write_s    = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            state_d       = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    pc_write_s    = run_pc_s;
                    ifid_hz_s     = run_hz_s;
                    ifid_flush_s  = run_flush_s;
                    idex_bubble_s = run_bubble_s;
                    freeze_s      = run_freeze_s;
                    state_d       = run_next_s;
                end
                STALL1: begin
                    if (dmem_stall_i) begin
                        freeze_s   = 1'b1;
                        pc_write_s = 1'b0;
                        ifid_hz_s  = 1'b1;
                        state_d    = STALL1;
                    end else begin
                        pc_write_s    = 1'b0;
                        ifid_hz_s     = 1'b1;
                        idex_bubble_s = 1'b1;
                        state_d       = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_stall_i) begin
                        freeze_s   = 1'b1;
                        pc_write_s = 1'b0;
                        ifid_hz_s  = 1'b1;
                        state_d    = MEM_WAIT;
                    end else begin
                        pc_write_s    = run_pc_s;
                        ifid_hz_s     = run_hz_s;
                        ifid_flush_s  = run_flush_s;
                        idex_bubble_s = run_bubble_s;
                        freeze_s      = run_freeze_s;
                        state_d       = run_next_s;
                    end
                end
                default: begin
                    // Unreachable encoding: squash the front end and recover to RUN
                    pc_write_s    = 1'b0;
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    state_d       = RUN;
                end
            endcase
        end
    end

    // Memory-wait timer and sticky timeout flag
    always_comb begin
        if ((state_q != MEM_WAIT) && (state_d == MEM_WAIT)) begin
            wait_d = 8'd0;
        end else if ((state_q == MEM_WAIT) && dmem_stall_i && (wait_q < TIMEOUT_C)) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
        err_d = err_q | (wait_d == TIMEOUT_C);
    end

    // State, timer and error registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign pc_write_o    = pc_write_s;
    assign ifid_hz_o     = ifid_hz_s;
    assign ifid_flush_o  = ifid_flush_s;
    assign idex_bubble_o = idex_bubble_s;
    assign freeze_o      = freeze_s;
    assign err_o         = err_q;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
    endfunction

    // Next value of the saturating performance counters
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, !pc_write_s);
        flush_cnt_d = sat_inc(flush_cnt_q, ifid_flush_s);
    end

    // Performance counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = {CNT_W{1'b0}};
    assign flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int CNT_W = 16;
    localparam int TO    = 64;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs_i, id_rt_i, ex_wreg_i;
    logic             id_uses_rt_i, id_branch_i, id_branch_taken_i;
    logic             ex_regwrite_i, ex_memread_i, imem_ready_i, dmem_stall_i;
    logic             pc_write_o, ifid_hz_o, ifid_flush_o, idex_bubble_o, freeze_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: "one more bubble owed", "waiting on data memory", stalled-cycle tally
    bit m_extra, m_waiting, m_err;
    int m_wait, m_stall, m_flush;
    logic e_pc, e_hz, e_fl, e_bub, e_frz, e_lu;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
        .id_branch_i(id_branch_i), .id_branch_taken_i(id_branch_taken_i),
        .ex_wreg_i(ex_wreg_i), .ex_regwrite_i(ex_regwrite_i), .ex_memread_i(ex_memread_i),
        .imem_ready_i(imem_ready_i), .dmem_stall_i(dmem_stall_i),
        .pc_write_o(pc_write_o), .ifid_hz_o(ifid_hz_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o), .err_o(err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic br, input logic tk, input logic [4:0] wreg,
                         input logic rw, input logic mr, input logic imr, input logic ds);
        id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = uses; id_branch_i = br;
        id_branch_taken_i = tk; ex_wreg_i = wreg; ex_regwrite_i = rw;
        ex_memread_i = mr; imem_ready_i = imr; dmem_stall_i = ds;
    endtask

    task automatic model_eval();
        logic hit;
        hit  = (ex_wreg_i != 5'd0) &&
               ((ex_wreg_i == id_rs_i) || (id_uses_rt_i && ex_wreg_i == id_rt_i));
        e_lu = ex_memread_i && hit;
        e_pc = 1'b1; e_hz = 1'b0; e_fl = 1'b0; e_bub = 1'b0; e_frz = 1'b0;
        if (rst_i) begin
            e_pc = 1'b0; e_fl = 1'b1; e_bub = 1'b1;
        end else if (dmem_stall_i) begin
            e_frz = 1'b1; e_pc = 1'b0; e_hz = 1'b1;
        end else if (m_extra || e_lu || (id_branch_i && ex_regwrite_i && hit)) begin
            e_pc = 1'b0; e_hz = 1'b1; e_bub = 1'b1;
        end else if (id_branch_taken_i) begin
            e_fl = 1'b1;
        end else if (!imem_ready_i) begin
            e_pc = 1'b0; e_fl = 1'b1;
        end
    endtask

    task automatic model_advance();
        if (rst_i) begin
            m_extra = 0; m_waiting = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_pc && m_stall < CMAX) m_stall++;
            if (e_fl && m_flush < CMAX) m_flush++;
            if (dmem_stall_i) begin
                if (!m_extra) begin
                    if (m_waiting) begin
                        if (m_wait < TO) m_wait++;
                        if (m_wait == TO) m_err = 1;
                    end else begin
                        m_waiting = 1;
                        m_wait    = 0;
                    end
                end
            end else begin
                m_waiting = 0;
                m_extra   = m_extra ? 1'b0 : (e_lu && id_branch_i);
            end
        end
    endtask

    task automatic cycle(input string tag);
        model_eval();
        @(negedge clk_i);
        chk({tag, ".pc_write"}, 32'(pc_write_o), 32'(e_pc));
        chk({tag, ".ifid_hz"}, 32'(ifid_hz_o), 32'(e_hz));
        chk({tag, ".ifid_flush"}, 32'(ifid_flush_o), 32'(e_fl));
        chk({tag, ".idex_bubble"}, 32'(idex_bubble_o), 32'(e_bub));
        chk({tag, ".freeze"}, 32'(freeze_o), 32'(e_frz));
        chk({tag, ".err"}, 32'(err_o), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(m_stall));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(m_flush));
`else
        chk({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'd0);
        chk({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'd0);
`endif
        @(posedge clk_i);
        model_advance();
        #1;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        m_extra = 0; m_waiting = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        rst_i = 1'b1;
        idle();
        @(posedge clk_i);
        #1;
        cycle("reset0");
        cycle("reset1");
        rst_i = 1'b0;
        idle();
        cycle("idle");

        // load-use on rt, single bubble
        drive(5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("lu_rt");
        idle();
        cycle("lu_rt_after");
        chk("lu_rt_pc_resumes", 32'(pc_write_o), 32'd1);

        // load feeding a branch: two bubbles
        drive(5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("lu_br0");
        idle();
        cycle("lu_br1");
        cycle("lu_br_done");

        // register zero never matches
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("reg_zero");

        // taken branch beats fetch miss, then fetch miss alone
        drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("taken_fetch_miss");
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("fetch_miss");

        // ALU result feeding a branch: one bubble, taken ignored
        drive(5'd4, 5'd2, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("brh");
        idle();
        cycle("brh_after");

        // data stall of 70 cycles with timeout, release into a taken branch
        drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 70; i++) cycle("dstall");
        chk("err_after_timeout", 32'(err_o), 32'd1);
        drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("dstall_release");
        idle();
        cycle("err_sticky");

        // data stall while a second bubble is owed
        drive(5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("s1_enter");
        drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle("s1_dstall");
        idle();
        cycle("s1_release");
        cycle("s1_done");

        // reset while a second bubble is owed
        drive(5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("rst_mid_enter");
        rst_i = 1'b1;
        cycle("rst_mid");
        rst_i = 1'b0;
        idle();
        cycle("rst_mid_after");
        chk("rst_mid_err_clear", 32'(err_o), 32'd0);

        // random traffic with a small register space to provoke matches
        for (int n = 0; n < 800; n++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 6) == 0));
            rst_i = ($urandom_range(0, 99) == 0);
            cycle("rand");
        end
        rst_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
